morse_char_decode: RTL and testbench
====================================

# morse_char_decode

Downstream of the Morse receiver FSM. Takes each received symbol pattern, the dot/dash bits plus an element count, and translates it to 8-bit ASCII. The result is buffered in a small FIFO and presented on a ready/valid byte stream to the UART transmitter or display stage. Throughput is one character per cycle, and overflow is reported rather than back-pressured, because the receiver cannot stall.

## Interface
- `FIFO_DEPTH`, 8: output FIFO entries; must be a power of 2, ≥2.
- `UNKNOWN_CHAR`, 8'h3F: ASCII emitted for invalid patterns ('?').
- `clk_100MHz` in 1: the single clock; all logic is rising-edge.
- `reset` in 1: asynchronous, active-high reset.
- `char_data` in 6: bit5 = space flag; bits[4:0] = elements, bit0 first, 1 = dash, 0 = dot.
- `char_len` in 3: number of valid elements, 1..5; ignored when bit5 is set.
- `char_valid` in 1: single-cycle qualifier for `char_data`/`char_len`; may be high on consecutive cycles.
- `ascii_data` out 8: decoded character at the FIFO head; 8'h00 when `ascii_valid`=0.
- `ascii_valid` out 1: FIFO non-empty.
- `ascii_ready` in 1: consumer accepts the byte when `ascii_valid && ascii_ready`.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: current occupancy.
- `overflow` out 1: sticky; set when a decoded character is dropped because the FIFO is full.

## Operation
- **Capture stage:** on `char_valid`, register `char_data`, `char_len` and a `cap_valid` flag. `cap_valid` clears the next cycle unless `char_valid` is high again.
- **Lookup** (combinational from the capture registers):
  - space flag → 8'h20.
  - `len` 1–4 → letters A–Z, International Morse.
  - `len` 5 → digits 0–9.
  - `len` 0, 6 or 7, and any unassigned pattern → `UNKNOWN_CHAR`.
  - Element bits at positions ≥ `len` are ignored; upstream may leave stale bits there.
- **Space collapsing:** a `last_was_space` flag, set at reset, drives two rules.
  - A space is discarded when `last_was_space`=1. This removes a leading space and repeated spaces.
  - Any written non-space clears the flag; a written space sets it.
  - A discarded space neither writes nor sets `overflow`.
- **Write:** when `cap_valid` and the character is not discarded, push it to the FIFO.
- **Full FIFO:**
  - If the FIFO is full and no pop occurs in the same cycle, the character is dropped and `overflow`←1. `last_was_space` is still updated as if written.
  - A push and a pop in the same cycle at full both proceed; `fifo_count` is unchanged.
- **Empty FIFO:** a pop is impossible. A push into an empty FIFO becomes visible the next cycle; there is no bypass path.
- **Handshake:** `ascii_data` stays stable while `ascii_valid && !ascii_ready`. `ascii_valid` never drops without a pop.
- **Output state machine:** `EMPTY`, `HOLD`, `FULL`, derived from the pointers.
  - EMPTY→HOLD on push.
  - HOLD→EMPTY on a pop with count 1 and no push.
  - HOLD→FULL on a push without a pop when count is `FIFO_DEPTH`-1.
  - FULL→HOLD on a pop without a push.

## Timing
- Latency: `char_valid` at cycle N gives capture at N+1 and the FIFO write at the N+2 edge. `ascii_valid` rises in cycle N+2 when the FIFO was empty.
- Pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally. Full is `count==FIFO_DEPTH`; empty is `count==0`.
- Reset values, asserted asynchronously and released synchronously to the design:
  - outputs: `ascii_valid`=0, `ascii_data`=8'h00, `fifo_count`=0, `overflow`=0.
  - internal: `cap_valid`=0, `last_was_space`=1, FIFO pointers 0.
- Reset mid-operation flushes all buffered and captured characters. There is no partial output afterwards.
- `overflow` clears only on reset.

## Structure
- **`morse_pkg`** holds:
  - the ASCII constants (`ASCII_SPACE`).
  - the `morse_sym_t` packed struct {space, elems[4:0]}.
  - the `morse_lookup(len, elems)` function, shared with any future transmit-side encoder.
- **`sync_fifo`** is one sub-module: a parameterised width/depth FIFO with the occupancy count. The decode logic and the space-collapse logic stay in the top module.

## Test plan
- **Single letter:** `char_data`=6'b000010, `char_len`=2 ('.-'), `ascii_ready`=1 → `ascii_data`=8'h41 ('A') with `ascii_valid` high for exactly one cycle, 2 cycles after input.
- **Digits and unknowns:**
  - len5 00000 → 8'h35 ('5').
  - len5 11110 → 8'h31 ('1').
  - len5 10101 → 8'h3F.
  - len4 1111 → 8'h3F.
  - len0 → 8'h3F.
- **Space collapsing:** space right after reset → no output. Then E (len1, 0), space, space, T (len1, 1) → output 8'h45, 8'h20, 8'h54 only.
- **Overflow:** `ascii_ready`=0, 9 back-to-back letters → `fifo_count`=8, `overflow`=1, ninth dropped. Then `ascii_ready`=1 → 8 bytes drain in order, `overflow` stays 1.
- **Push and pop at full:** FIFO full, push and pop in the same cycle → `fifo_count` stays 8, `overflow` stays 0, and the new byte is at the tail.
- **Reset mid-drain:** `reset` asserted mid-drain → `ascii_valid`=0 and `fifo_count`=0 immediately. After release, the first space is suppressed.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared Morse definitions: ASCII constants, received-symbol layout and the
// pattern-to-ASCII lookup used by the decoder (and any future encoder).
package morse_pkg;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_NUL   = 8'h00;

    typedef struct packed {
        logic       space;
        logic [4:0] elems;
    } morse_sym_t;

    // Returns ASCII_NUL for any unassigned pattern; elems bit0 is the first element, 1 = dash.
    function automatic logic [7:0] morse_lookup(input logic [2:0] len, input logic [4:0] elems);
        logic [4:0] p;
        p = elems & ((5'd1 << len) - 5'd1);
        morse_lookup = ASCII_NUL;
        case (len)
            3'd1: case (p)
                5'd0:    morse_lookup = "E";
                5'd1:    morse_lookup = "T";
                default: morse_lookup = ASCII_NUL;
            endcase
            3'd2: case (p)
                5'd0:    morse_lookup = "I";
                5'd1:    morse_lookup = "N";
                5'd2:    morse_lookup = "A";
                5'd3:    morse_lookup = "M";
                default: morse_lookup = ASCII_NUL;
            endcase
            3'd3: case (p)
                5'd0:    morse_lookup = "S";
                5'd1:    morse_lookup = "D";
                5'd2:    morse_lookup = "R";
                5'd3:    morse_lookup = "G";
                5'd4:    morse_lookup = "U";
                5'd5:    morse_lookup = "K";
                5'd6:    morse_lookup = "W";
                5'd7:    morse_lookup = "O";
                default: morse_lookup = ASCII_NUL;
            endcase
            3'd4: case (p)
                5'd0:    morse_lookup = "H";
                5'd1:    morse_lookup = "B";
                5'd2:    morse_lookup = "L";
                5'd3:    morse_lookup = "Z";
                5'd4:    morse_lookup = "F";
                5'd5:    morse_lookup = "C";
                5'd6:    morse_lookup = "P";
                5'd8:    morse_lookup = "V";
                5'd9:    morse_lookup = "X";
                5'd11:   morse_lookup = "Q";
                5'd13:   morse_lookup = "Y";
                5'd14:   morse_lookup = "J";
                default: morse_lookup = ASCII_NUL;
            endcase
            3'd5: case (p)
                5'd31:   morse_lookup = "0";
                5'd30:   morse_lookup = "1";
                5'd28:   morse_lookup = "2";
                5'd24:   morse_lookup = "3";
                5'd16:   morse_lookup = "4";
                5'd0:    morse_lookup = "5";
                5'd1:    morse_lookup = "6";
                5'd3:    morse_lookup = "7";
                5'd7:    morse_lookup = "8";
                5'd15:   morse_lookup = "9";
                default: morse_lookup = ASCII_NUL;
            endcase
            default: morse_lookup = ASCII_NUL;
        endcase
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Parameterised synchronous FIFO with occupancy count and an EMPTY/HOLD/FULL
// state register; the head word reads as zero while empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {StEmpty, StHold, StFull} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count_q, count_d;
    logic              push_ok, pop_ok;

    assign pop_ok  = pop && (state_q != StEmpty);
    // At full a push only proceeds when a pop frees the head slot in the same cycle.
    assign push_ok = push && ((state_q != StFull) || pop_ok);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StEmpty: if (push_ok) state_d = StHold;
            StHold: begin
                if (pop_ok && !push_ok && count_q == CW'(1)) begin
                    state_d = StEmpty;
                end else if (push_ok && !pop_ok && count_q == CW'(DEPTH - 1)) begin
                    state_d = StFull;
                end
            end
            StFull:  if (pop_ok && !push_ok) state_d = StHold;
            default: state_d = StEmpty;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StEmpty;
            count_q <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

    assign valid = (state_q != StEmpty);
    assign full  = (state_q == StFull);
    assign rdata = valid ? mem[rd_ptr] : '0;
    assign count = count_q;

endmodule

// File: rtl/morse_char_decode.sv
// Captures received Morse symbols, decodes them to ASCII with space collapsing,
// and buffers the bytes on a ready/valid stream; drops are flagged, never stalled.
module morse_char_decode
    import morse_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter logic [7:0]  UNKNOWN_CHAR = 8'h3F
) (
    input  logic                          clk_100MHz,
    input  logic                          reset,
    input  logic [5:0]                    char_data,
    input  logic [2:0]                    char_len,
    input  logic                          char_valid,
    output logic [7:0]                    ascii_data,
    output logic                          ascii_valid,
    input  logic                          ascii_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    morse_sym_t cap_sym;
    logic [2:0] cap_len;
    logic       cap_valid;
    logic       last_was_space;
    logic [7:0] lookup_char;
    logic [7:0] decoded;
    logic       discard;
    logic       write;
    logic       fifo_full;

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            cap_valid <= 1'b0;
            cap_sym   <= '0;
            cap_len   <= '0;
        end else begin
            cap_valid <= char_valid;
            if (char_valid) begin
                cap_sym <= morse_sym_t'(char_data);
                cap_len <= char_len;
            end
        end
    end

    assign lookup_char = morse_lookup(cap_len, cap_sym.elems);
    assign decoded     = cap_sym.space ? ASCII_SPACE
                       : (lookup_char == ASCII_NUL) ? UNKNOWN_CHAR : lookup_char;
    assign discard     = cap_sym.space && last_was_space;
    assign write       = cap_valid && !discard;

    // A dropped character still counts as written for the space-collapse history.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            last_was_space <= 1'b1;
            overflow       <= 1'b0;
        end else begin
            if (write) last_was_space <= cap_sym.space;
            if (write && fifo_full && !ascii_ready) overflow <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_100MHz),
        .reset (reset),
        .push  (write),
        .wdata (decoded),
        .pop   (ascii_ready),
        .rdata (ascii_data),
        .valid (ascii_valid),
        .full  (fifo_full),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_morse_char_decode.sv
// Randomised and directed stimulus for morse_char_decode, checked every cycle
// against a queue-based model that decodes via a Morse string table.
module tb_morse_char_decode;

    localparam int DEPTH = 8;

    logic       clk_100MHz = 1'b0;
    logic       reset;
    logic [5:0] char_data;
    logic [2:0] char_len;
    logic       char_valid;
    logic [7:0] ascii_data;
    logic       ascii_valid;
    logic       ascii_ready;
    logic [3:0] fifo_count;
    logic       overflow;

    always #5 clk_100MHz = ~clk_100MHz;

    morse_char_decode #(
        .FIFO_DEPTH   (DEPTH),
        .UNKNOWN_CHAR (8'h3F)
    ) dut (
        .clk_100MHz  (clk_100MHz),
        .reset       (reset),
        .char_data   (char_data),
        .char_len    (char_len),
        .char_valid  (char_valid),
        .ascii_data  (ascii_data),
        .ascii_valid (ascii_valid),
        .ascii_ready (ascii_ready),
        .fifo_count  (fifo_count),
        .overflow    (overflow)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // A..Z then 0..9, written as dot/dash strings.
    string morse_tab [36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                              ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                              "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
                              "-----", ".----", "..---", "...--", "....-", ".....", "-....",
                              "--...", "---..", "----."};

    function automatic logic [7:0] ref_char(input logic [5:0] d, input logic [2:0] l);
        string s;
        s = "";
        if (d[5]) return 8'h20;
        if (l == 3'd0 || l > 3'd5) return 8'h3F;
        for (int i = 0; i < int'(l); i++) begin
            if (d[i]) s = $sformatf("%s-", s);
            else      s = $sformatf("%s.", s);
        end
        for (int k = 0; k < 36; k++) begin
            if (morse_tab[k] == s) return (k < 26) ? 8'(65 + k) : 8'(48 + k - 26);
        end
        return 8'h3F;
    endfunction

    logic [7:0] mq [$];
    bit         m_cap_v;
    logic [5:0] m_cap_d;
    logic [2:0] m_cap_l;
    bit         m_last_sp;
    bit         m_ovf;

    task automatic model_reset();
        mq.delete();
        m_cap_v   = 1'b0;
        m_cap_d   = '0;
        m_cap_l   = '0;
        m_last_sp = 1'b1;
        m_ovf     = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        bit pop;
        bit is_sp;
        pop = (mq.size() != 0) && ascii_ready;
        if (pop) void'(mq.pop_front());
        if (m_cap_v) begin
            is_sp = m_cap_d[5];
            if (!(is_sp && m_last_sp)) begin
                if (mq.size() < DEPTH) mq.push_back(ref_char(m_cap_d, m_cap_l));
                else m_ovf = 1'b1;
                m_last_sp = is_sp;
            end
        end
        m_cap_v = char_valid;
        if (char_valid) begin
            m_cap_d = char_data;
            m_cap_l = char_len;
        end
    endtask

    task automatic check_outputs();
        check_eq("ascii_valid", 32'(ascii_valid), 32'(mq.size() != 0));
        check_eq("ascii_data", 32'(ascii_data), (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
        check_eq("fifo_count", 32'(fifo_count), 32'(mq.size()));
        check_eq("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic step(input logic v, input logic [5:0] d, input logic [2:0] l, input logic r);
        char_valid  = v;
        char_data   = d;
        char_len    = l;
        ascii_ready = r;
        model_edge();
        @(posedge clk_100MHz);
        @(negedge clk_100MHz);
        check_outputs();
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) step(1'b0, 6'h00, 3'd0, r);
    endtask

    task automatic rand_letter(input logic r);
        step(1'b1, {1'b0, 5'($urandom)}, 3'($urandom_range(1, 5)), r);
    endtask

    task automatic do_reset();
        char_valid = 1'b0;
        reset      = 1'b1;
        #1;
        model_reset();
        check_eq("rst_valid", 32'(ascii_valid), 32'h0);
        check_eq("rst_count", 32'(fifo_count), 32'h0);
        check_eq("rst_data", 32'(ascii_data), 32'h0);
        check_eq("rst_overflow", 32'(overflow), 32'h0);
        @(negedge clk_100MHz);
        @(negedge clk_100MHz);
        reset = 1'b0;
    endtask

    localparam logic [5:0] SP = 6'b100000;

    initial begin
        char_valid  = 1'b0;
        char_data   = '0;
        char_len    = '0;
        ascii_ready = 1'b0;
        reset       = 1'b0;
        @(negedge clk_100MHz);
        do_reset();

        // single letter 'A'
        step(1'b1, 6'b000010, 3'd2, 1'b1);
        idle(4, 1'b1);

        // digits, unknowns, stale upper bits
        step(1'b1, 6'b000000, 3'd5, 1'b1);
        step(1'b1, 6'b011110, 3'd5, 1'b1);
        step(1'b1, 6'b010101, 3'd5, 1'b1);
        step(1'b1, 6'b001111, 3'd4, 1'b1);
        step(1'b1, 6'b000000, 3'd0, 1'b1);
        step(1'b1, 6'b011010, 3'd2, 1'b1);
        step(1'b1, 6'b000001, 3'd6, 1'b1);
        idle(5, 1'b1);

        // space collapsing
        do_reset();
        step(1'b1, SP, 3'd0, 1'b1);
        idle(3, 1'b1);
        step(1'b1, 6'b000000, 3'd1, 1'b1);
        step(1'b1, SP, 3'd3, 1'b1);
        step(1'b1, SP, 3'd2, 1'b1);
        step(1'b1, 6'b000001, 3'd1, 1'b1);
        idle(5, 1'b1);

        // push and pop together at full
        for (int i = 0; i < DEPTH; i++) rand_letter(1'b0);
        idle(2, 1'b0);
        step(1'b1, 6'b000001, 3'd1, 1'b0);
        step(1'b0, 6'h00, 3'd0, 1'b1);
        idle(1, 1'b0);
        idle(10, 1'b1);

        // overflow
        for (int i = 0; i < DEPTH + 1; i++) rand_letter(1'b0);
        idle(3, 1'b0);
        idle(10, 1'b1);

        // reset mid-drain, then leading space suppressed
        for (int i = 0; i < 6; i++) rand_letter(1'b0);
        idle(2, 1'b0);
        idle(3, 1'b1);
        do_reset();
        step(1'b1, SP, 3'd0, 1'b1);
        idle(3, 1'b1);
        step(1'b1, 6'b000000, 3'd1, 1'b1);
        idle(3, 1'b1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) != 0,
                     {$urandom_range(0, 4) == 0, 5'($urandom)},
                     3'($urandom),
                     (i % 400 < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
